alu_muldiv_ctrl: RTL and testbench
==================================

ALU_MULDIV_CTRL -- requirements
Module: alu_muldiv_ctrl

Interface
REQ-001: Parameter DATA_W, default 16, datapath width; only 16 is supported.
REQ-002: clk  input  1  rising-edge clock; sole clock domain.
REQ-003: rst  input  1  reset, asynchronous, active-low.
REQ-004: start  input  1  request pulse; sampled only in IDLE.
REQ-005: is_div  input  1  with start: 0 = multiply (low 16 bits), 1 = unsigned divide.
REQ-006: op_a / op_b  input  16 each  multiplicand/multiplier or dividend/divisor; captured with start.
REQ-007: abort  input  1  pipeline flush; cancels the operation in progress.
REQ-008: busy  output  1  operation in progress, including the DONE cycle.
REQ-009: done  output  1  single-cycle completion pulse.
REQ-010: result_lo / result_hi  output  16 each  product/0, or quotient/remainder.
REQ-011: div_zero  output  1  last divide had divisor 0.
REQ-012: alu_op  output  4  op to shared ALU: 0000 ADD, 0001 SUB, 0110 SHL, 0111 SLT, 1000 ZERO.
REQ-013: alu_first / alu_second  output  16 each  ALU operands, driven combinationally from state.
REQ-014: alu_result  input  16  combinational ALU result, captured at the clock edge.

Function
REQ-015: States are IDLE, MUL_ADD, MUL_SHL, DIV_CMP, DIV_SUB, DONE, plus a 4-bit iteration counter.
REQ-016: In IDLE with start=1, the block latches the operands, clears acc/quotient/remainder/counter, and moves to MUL_ADD (is_div=0) or DIV_CMP (is_div=1, op_b!=0).
REQ-017: Divide with op_b=0 goes IDLE->DONE; result_lo=0xFFFF, result_hi=op_a, div_zero=1, and done is asserted in the cycle after start is sampled.
REQ-018: MUL_ADD drives ADD(acc, mcand); acc takes alu_result only if mplier[0]=1; next state is MUL_SHL.
REQ-019: MUL_SHL drives SHL(mcand, 16'd1); mcand takes alu_result, mplier shifts right 1 internally, and the counter increments; after the 16th iteration the next state is DONE, otherwise MUL_ADD.
REQ-020: DIV_CMP computes rsh={rem[14:0],dvd[15]} and ovf=rem[15], and drives SLT(rsh, divisor); at the edge: rem<=rsh, dvd<<=1, take<=ovf | ~alu_result[0]; next state is DIV_SUB.
REQ-021: DIV_SUB drives SUB(rem, divisor); rem<=alu_result if take, and quot<={quot[14:0],take}; counter increments; after the 16th iteration the next state is DONE, otherwise DIV_CMP.
REQ-022: All arithmetic is modulo 2^16; the ovf bit guarantees correct restoring division for divisor>=0x8000.
REQ-023: Fixed latency: for a non-zero-divisor operation, done is asserted in the 33rd cycle after the edge that samples start (32 work cycles + DONE).
REQ-024: DONE asserts done for exactly one cycle, updates result_lo/result_hi/div_zero, and returns to IDLE; results hold until the next DONE.
REQ-025: start outside IDLE (busy or DONE cycle) is ignored and never queued.
REQ-026: abort=1 in any non-IDLE state returns to IDLE at the next edge with no done pulse and results unchanged; abort in IDLE has no effect; abort wins over a simultaneous DONE transition.
REQ-027: In IDLE, alu_op=1000 and alu_first=alu_second=0.
REQ-028: busy=1 in every state except IDLE.

Reset
REQ-029: rst=0 forces IDLE immediately, regardless of clk.
REQ-030: rst=0 clears busy, done, result_lo, result_hi, div_zero, the counter and all internal registers to 0.
REQ-031: Reset asserted mid-operation discards the operation; no done is produced after release.
REQ-032: The first start is accepted on the first rising edge with rst=1.

Verification
REQ-033: mul 0x0007*0x0009 -> done at cycle 33, result_lo=0x003F, result_hi=0x0000, div_zero=0.
REQ-034: mul 0xFFFF*0xFFFF -> result_lo=0x0001, result_hi=0x0000; also check the ALU op sequence alternates 0000/0110 sixteen times.
REQ-035: div 100/7 -> result_lo=0x000E, result_hi=0x0002; div 0xFFFF/0x8001 -> result_lo=0x0001, result_hi=0x7FFE.
REQ-036: div 0x1234/0x0000 -> done one cycle after start, result_lo=0xFFFF, result_hi=0x1234, div_zero=1.
REQ-037: mul started, abort at cycle 10 -> IDLE next cycle, no done, prior results retained; start during busy -> ignored.
REQ-038: rst low at cycle 20 of a divide -> all outputs 0 asynchronously; after release, div 9/3 -> result_lo=0x0003, result_hi=0x0000.

Source files
------------

// File: rtl/alu_muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer that borrows an external shared ALU.
// Shift-add multiply (low half) and restoring unsigned divide, 16 iterations each.
module alu_muldiv_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_div,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result_lo,
    output logic [DATA_W-1:0] result_hi,
    output logic              div_zero,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_first,
    output logic [DATA_W-1:0] alu_second,
    input  logic [DATA_W-1:0] alu_result
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SHL  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_ZERO = 4'b1000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_ADD = 3'd1,
        MUL_SHL = 3'd2,
        DIV_CMP = 3'd3,
        DIV_SUB = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic              take_q, take_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] result_lo_q, result_lo_d;
    logic [DATA_W-1:0] result_hi_q, result_hi_d;
    logic              div_zero_q, div_zero_d;
    logic [DATA_W-1:0] rsh;
    logic              ovf;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        dvd_d       = dvd_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        take_d      = take_q;
        done_d      = 1'b0;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;
        div_zero_d  = div_zero_q;
        alu_op      = OP_ZERO;
        alu_first   = '0;
        alu_second  = '0;
        // ovf is the bit shifted out of rem; when set the partial remainder exceeds any divisor
        rsh         = {rem_q[DATA_W-2:0], dvd_q[DATA_W-1]};
        ovf         = rem_q[DATA_W-1];

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d   = op_a;
                    mplier_d  = op_b;
                    dvd_d     = op_a;
                    divisor_d = op_b;
                    acc_d     = '0;
                    rem_d     = '0;
                    quot_d    = '0;
                    cnt_d     = '0;
                    take_d    = 1'b0;
                    if (!is_div) begin
                        state_d = MUL_ADD;
                    end else if (op_b != '0) begin
                        state_d = DIV_CMP;
                    end else begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        result_lo_d = '1;
                        result_hi_d = op_a;
                        div_zero_d  = 1'b1;
                    end
                end
            end
            MUL_ADD: begin
                alu_op     = OP_ADD;
                alu_first  = acc_q;
                alu_second = mcand_q;
                if (mplier_q[0]) acc_d = alu_result;
                state_d = MUL_SHL;
            end
            MUL_SHL: begin
                alu_op     = OP_SHL;
                alu_first  = mcand_q;
                alu_second = DATA_W'(1);
                mcand_d    = alu_result;
                mplier_d   = mplier_q >> 1;
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == 4'hF) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    result_lo_d = acc_q;
                    result_hi_d = '0;
                    div_zero_d  = 1'b0;
                end else begin
                    state_d = MUL_ADD;
                end
            end
            DIV_CMP: begin
                alu_op     = OP_SLT;
                alu_first  = rsh;
                alu_second = divisor_q;
                rem_d      = rsh;
                dvd_d      = dvd_q << 1;
                take_d     = ovf | ~alu_result[0];
                state_d    = DIV_SUB;
            end
            DIV_SUB: begin
                alu_op     = OP_SUB;
                alu_first  = rem_q;
                alu_second = divisor_q;
                if (take_q) rem_d = alu_result;
                quot_d = {quot_q[DATA_W-2:0], take_q};
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'hF) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    result_lo_d = quot_d;
                    result_hi_d = rem_d;
                    div_zero_d  = 1'b0;
                end else begin
                    state_d = DIV_CMP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything, including a completion that would land this edge
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            done_d      = 1'b0;
            result_lo_d = result_lo_q;
            result_hi_d = result_hi_q;
            div_zero_d  = div_zero_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            dvd_q       <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            take_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_lo_q <= '0;
            result_hi_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            dvd_q       <= dvd_d;
            divisor_q   <= divisor_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            take_q      <= take_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_lo = result_lo_q;
    assign result_hi = result_hi_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed bench for alu_muldiv_ctrl: vector table plus abort/reset/ignored-start sequences.
// Includes a small model of the shared ALU that the sequencer drives.
module tb_alu_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_div;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic        div_zero;
    logic [3:0]  alu_op;
    logic [15:0] alu_first;
    logic [15:0] alu_second;
    logic [15:0] alu_result;

    int n_run  = 0;
    int n_fail = 0;
    logic [3:0] op_log [0:63];

    alu_muldiv_ctrl #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_div     (is_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .result_lo  (result_lo),
        .result_hi  (result_hi),
        .div_zero   (div_zero),
        .alu_op     (alu_op),
        .alu_first  (alu_first),
        .alu_second (alu_second),
        .alu_result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU; SLT is an unsigned compare here since the divider is unsigned
    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_first + alu_second;
            4'b0001: alu_result = alu_first - alu_second;
            4'b0110: alu_result = alu_first << alu_second[3:0];
            4'b0111: alu_result = {15'd0, (alu_first < alu_second)};
            default: alu_result = 16'd0;
        endcase
    end

    typedef struct {
        logic        is_div;
        logic [15:0] a;
        logic [15:0] b;
        int          lat;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        dz;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; start is sampled by the next rising edge, returns in cycle 1
    task automatic issue(input logic d, input logic [15:0] a, input logic [15:0] b);
        start  = 1'b1;
        is_div = d;
        op_a   = a;
        op_b   = b;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int first, input int maxc, output int lat);
        int c;
        c = first;
        while (done !== 1'b1 && c < maxc) begin
            if (c < 64) op_log[c] = alu_op;
            @(negedge clk);
            c++;
        end
        lat = (done === 1'b1) ? c : -1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int seen;

        vecs[0] = '{1'b0, 16'h0007, 16'h0009, 33, 16'h003F, 16'h0000, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 33, 16'h0001, 16'h0000, 1'b0};
        vecs[2] = '{1'b1, 16'd100,  16'd7,    33, 16'h000E, 16'h0002, 1'b0};
        vecs[3] = '{1'b1, 16'hFFFF, 16'h8001, 33, 16'h0001, 16'h7FFE, 1'b0};
        vecs[4] = '{1'b1, 16'h1234, 16'h0000, 1,  16'hFFFF, 16'h1234, 1'b1};
        vecs[5] = '{1'b0, 16'h1234, 16'h0010, 33, 16'h2340, 16'h0000, 1'b0};
        vecs[6] = '{1'b1, 16'h8000, 16'h0003, 33, 16'h2AAA, 16'h0002, 1'b0};
        vecs[7] = '{1'b1, 16'h0005, 16'h0009, 33, 16'h0000, 16'h0005, 1'b0};

        rst = 1'b0; start = 1'b0; is_div = 1'b0; op_a = '0; op_b = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_lo", 32'(result_lo), 32'd0);
        chk("rst_hi", 32'(result_hi), 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        chk("idle_op", 32'(alu_op), 32'h8);
        chk("idle_first", 32'(alu_first), 32'd0);
        chk("idle_second", 32'(alu_second), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].is_div, vecs[i].a, vecs[i].b);
            wait_done(1, 40, lat);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_lo", i), 32'(result_lo), 32'(vecs[i].lo));
            chk($sformatf("v%0d_hi", i), 32'(result_hi), 32'(vecs[i].hi));
            chk($sformatf("v%0d_dz", i), 32'(div_zero), 32'(vecs[i].dz));
            chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'd1);
            if (i == 1) begin
                for (int k = 1; k <= 32; k++)
                    chk($sformatf("mul_op_seq%0d", k), 32'(op_log[k]),
                        (k % 2 == 1) ? 32'h0 : 32'h6);
            end
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_hold", i), 32'(result_lo), 32'(vecs[i].lo));
        end

        // start while busy must not recapture operands
        issue(1'b0, 16'd3, 16'd5);
        repeat (4) @(negedge clk);
        start = 1'b1; is_div = 1'b1; op_a = 16'h1234; op_b = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy_nodone", 32'(done), 32'd0);
        wait_done(6, 40, lat);
        chk("ign_lat", lat, 33);
        chk("ign_lo", 32'(result_lo), 32'd15);
        chk("ign_dz", 32'(div_zero), 32'd0);
        // start during the DONE cycle is dropped, not queued
        start = 1'b1; is_div = 1'b1; op_a = 16'h1234; op_b = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        chk("ign_done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("ign_done_nodone", 32'(done), 32'd0);

        // abort at cycle 10
        issue(1'b0, 16'd7, 16'd9);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        wait_done(11, 60, lat);
        chk("abort_no_done", lat, -1);
        chk("abort_lo_kept", 32'(result_lo), 32'd15);
        chk("abort_hi_kept", 32'(result_hi), 32'd0);

        // abort in IDLE does not block a start
        abort = 1'b1;
        issue(1'b1, 16'd100, 16'd7);
        abort = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd1);
        wait_done(1, 40, lat);
        chk("abort_idle_lat", lat, 33);
        chk("abort_idle_lo", 32'(result_lo), 32'hE);
        chk("abort_idle_hi", 32'(result_hi), 32'h2);
        @(negedge clk);

        // abort on the last work cycle beats completion
        issue(1'b0, 16'd2, 16'd3);
        repeat (31) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_last_done", 32'(done), 32'd0);
        chk("abort_last_busy", 32'(busy), 32'd0);
        chk("abort_last_lo", 32'(result_lo), 32'hE);
        chk("abort_last_hi", 32'(result_hi), 32'h2);

        // divide by zero ahead of reset so every result register is non-zero
        issue(1'b1, 16'hABCD, 16'h0000);
        chk("dz_done", 32'(done), 32'd1);
        chk("dz_lo", 32'(result_lo), 32'hFFFF);
        chk("dz_hi", 32'(result_hi), 32'hABCD);
        chk("dz_flag", 32'(div_zero), 32'd1);
        @(negedge clk);

        // asynchronous reset at cycle 20 of a divide
        issue(1'b1, 16'hFFFF, 16'd3);
        repeat (19) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_lo", 32'(result_lo), 32'd0);
        chk("arst_hi", 32'(result_hi), 32'd0);
        chk("arst_dz", 32'(div_zero), 32'd0);
        chk("arst_op", 32'(alu_op), 32'h8);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1;
        end
        chk("arst_no_resume", seen, 0);
        issue(1'b1, 16'd9, 16'd3);
        wait_done(1, 40, lat);
        chk("post_rst_lat", lat, 33);
        chk("post_rst_lo", 32'(result_lo), 32'h3);
        chk("post_rst_hi", 32'(result_hi), 32'h0);
        chk("post_rst_dz", 32'(div_zero), 32'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
